// File: rtl/blackjack_pkg.sv
// Shared deck constants, dealer state encoding and card-decoding helpers.
package blackjack_pkg;

    localparam int DECK_SIZE  = 52;
    localparam int NUM_RANKS  = 13;
    localparam int FACE_VALUE = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PICK    = 2'd1,
        ST_DELIVER = 2'd2,
        ST_SHUFFLE = 2'd3
    } dealer_state_t;

    // Fold a 6-bit random value into the 0..51 card index range.
    function automatic logic [5:0] wrap_idx(input logic [5:0] raw);
        return (raw >= 6'(DECK_SIZE)) ? raw - 6'(DECK_SIZE) : raw;
    endfunction

    // Card index -> rank 1..13 (1 = ace, 11..13 = J, Q, K).
    function automatic logic [3:0] idx_rank(input logic [5:0] idx);
        return 4'(idx % 6'(NUM_RANKS)) + 4'd1;
    endfunction

    // Card index -> suit 0..3.
    function automatic logic [1:0] idx_suit(input logic [5:0] idx);
        return 2'(idx / 6'(NUM_RANKS));
    endfunction

    // Blackjack value: face cards count as ten, ace counts as one here.
    function automatic logic [7:0] rank_value(input logic [3:0] rank);
        return (rank > 4'(FACE_VALUE)) ? 8'(FACE_VALUE) : {4'd0, rank};
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, free-running outside reset.
module card_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    // Shift right, feeding the tap XOR into the top bit; reload seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else begin
            state <= {state[0] ^ state[2] ^ state[3] ^ state[5], state[15:1]};
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deals cards without replacement from a 52-card deck using an LFSR start
// point followed by a linear probe over the used-card bitmap.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | waiting; samples shuffle (priority) and draw_req
//   ST_PICK    | probing idx, stepping past cards already dealt
//   ST_DELIVER | card latched; raises card_valid on the way back to idle
//   ST_SHUFFLE | returns every card to the deck
module card_dealer
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       draw_req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic [7:0] card_value,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       busy
);

    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

    dealer_state_t state;
    logic [51:0]   used;
    logic [5:0]    idx;
    logic [15:0]   lfsr;
    logic [5:0]    lfsr_low;
    logic [9:0]    lfsr_hi_unused;

    card_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    // Only the low six bits pick the starting card.
    assign {lfsr_hi_unused, lfsr_low} = lfsr;

    assign deck_empty = (cards_left == 6'd0);
    assign busy       = (state != ST_IDLE);

    // Dealer FSM with registered card outputs; reset abandons any draw.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            used       <= '0;
            idx        <= '0;
            cards_left <= 6'(DECK_SIZE);
            card_valid <= 1'b0;
            card_value <= '0;
            card_rank  <= '0;
            card_suit  <= '0;
        end else begin
            card_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (shuffle) begin
                        state <= ST_SHUFFLE;
                    end else if (draw_req && (cards_left != 6'd0)) begin
                        idx   <= wrap_idx(lfsr_low);
                        state <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    // Terminates because a draw only starts with a free card left.
                    if (used[idx]) begin
                        idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
                    end else begin
                        used[idx]  <= 1'b1;
                        cards_left <= cards_left - 6'd1;
                        card_rank  <= idx_rank(idx);
                        card_suit  <= idx_suit(idx);
                        card_value <= rank_value(idx_rank(idx));
                        state      <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    card_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
                ST_SHUFFLE: begin
                    used       <= '0;
                    cards_left <= 6'(DECK_SIZE);
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: randomized draws against a deck model that tracks
// dealt cards as an array and predicts the probe walk from the LFSR value.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst, draw_req, shuffle;
    logic       card_valid, deck_empty, busy;
    logic [7:0] card_value;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic [5:0] cards_left;

    logic       rst_c, draw_c, shuf_c;
    logic       c_card_valid, c_deck_empty, c_busy;
    logic [7:0] c_card_value;
    logic [3:0] c_card_rank;
    logic [1:0] c_card_suit;
    logic [5:0] c_cards_left;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [15:0] m_lfsr;
    bit         used_m[52];
    bit         seen[52];
    int         left_m;
    int         last_lat;

    always #5 clk = ~clk;

    card_dealer dut (
        .clk(clk), .rst(rst), .draw_req(draw_req), .shuffle(shuffle),
        .card_valid(card_valid), .card_value(card_value), .card_rank(card_rank),
        .card_suit(card_suit), .cards_left(cards_left), .deck_empty(deck_empty),
        .busy(busy)
    );

    card_dealer #(.LFSR_SEED(16'h000C)) dut_c (
        .clk(clk), .rst(rst_c), .draw_req(draw_c), .shuffle(shuf_c),
        .card_valid(c_card_valid), .card_value(c_card_value), .card_rank(c_card_rank),
        .card_suit(c_card_suit), .cards_left(c_cards_left), .deck_empty(c_deck_empty),
        .busy(c_busy)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] t;
        t = s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5);
        return (s >> 1) | ({15'd0, t[0]} << 15);
    endfunction

    // Reference random source for the default-seed dealer.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 52; i++) used_m[i] = 1'b0;
        left_m = 52;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 16'(card_valid), 16'd0);
        check({tag, "_value"}, 16'(card_value), 16'd0);
        check({tag, "_rank"},  16'(card_rank),  16'd0);
        check({tag, "_suit"},  16'(card_suit),  16'd0);
        check({tag, "_left"},  16'(cards_left), 16'd52);
        check({tag, "_empty"}, 16'(deck_empty), 16'd0);
        check({tag, "_busy"},  16'(busy),       16'd0);
    endtask

    // Called at a negedge with the dealer idle; returns at the negedge where
    // card_valid is seen (or the wait bound expires).
    task automatic do_draw(input bit keep);
        int idx, k, cnt, er, ev;
        bit got;
        idx = int'(m_lfsr & 16'h003F);
        if (idx >= 52) idx -= 52;
        k = 0;
        while (used_m[idx] && k < 52) begin
            idx = (idx + 1) % 52;
            k++;
        end
        er = idx % 13 + 1;
        ev = (er > 10) ? 10 : er;
        draw_req = 1'b1;
        @(negedge clk);
        if (!keep) draw_req = 1'b0;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 60) begin
            if (card_valid) got = 1'b1;
            else begin
                @(negedge clk);
                cnt++;
            end
        end
        last_lat = cnt;
        check("draw_latency", 16'(cnt), 16'(2 + k));
        check("draw_rank",  16'(card_rank),  16'(er));
        check("draw_suit",  16'(card_suit),  16'(idx / 13));
        check("draw_value", 16'(card_value), 16'(ev));
        check("draw_left",  16'(cards_left), 16'(left_m - 1));
        used_m[idx] = 1'b1;
        left_m--;
    endtask

    initial begin
        int oi;
        bit keep;
        rst = 1'b1; draw_req = 1'b0; shuffle = 1'b0;
        rst_c = 1'b1; draw_c = 1'b0; shuf_c = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // First draw straight out of reset with the default seed.
        do_draw(1'b0);
        check("first_latency", 16'(last_lat),   16'd2);
        check("first_rank",    16'(card_rank),  16'd8);
        check("first_suit",    16'(card_suit),  16'd2);
        check("first_value",   16'(card_value), 16'd8);
        check("first_left",    16'(cards_left), 16'd51);

        // Random gaps and held draw_req down to 40 cards.
        while (left_m > 40) begin
            keep = (left_m > 41) && ($urandom_range(0, 1) == 1);
            do_draw(keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check("left_40", 16'(cards_left), 16'd40);

        // Shuffle and draw together: shuffle wins, draw dropped.
        shuffle = 1'b1; draw_req = 1'b1;
        @(negedge clk);
        shuffle = 1'b0; draw_req = 1'b0;
        check("both_busy",  16'(busy),       16'd1);
        check("both_valid", 16'(card_valid), 16'd0);
        @(negedge clk);
        check("both_left",  16'(cards_left), 16'd52);
        check("both_idle",  16'(busy),       16'd0);
        check("both_valid2", 16'(card_valid), 16'd0);
        model_reset();

        // Deal the whole deck; every card must be distinct.
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        for (int n = 0; n < 52; n++) begin
            keep = (n < 51) && ($urandom_range(0, 2) == 0);
            do_draw(keep);
            oi = int'(card_suit) * 13 + int'(card_rank) - 1;
            if (oi < 0 || oi > 51) oi = 0;
            check("distinct", 16'(seen[oi]), 16'd0);
            seen[oi] = 1'b1;
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check("empty_left", 16'(cards_left), 16'd0);
        check("empty_flag", 16'(deck_empty), 16'd1);

        // Draw on an empty deck is ignored.
        draw_req = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("empty_draw_valid", 16'(card_valid), 16'd0);
            check("empty_draw_busy",  16'(busy),       16'd0);
        end
        draw_req = 1'b0;

        // Shuffle refills the deck; the next draw succeeds.
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        check("shuf_busy", 16'(busy), 16'd1);
        @(negedge clk);
        check("shuf_left",  16'(cards_left), 16'd52);
        check("shuf_empty", 16'(deck_empty), 16'd0);
        model_reset();
        do_draw(1'b0);

        // Down to one card, then reset in the middle of the last pick.
        while (left_m > 1) do_draw(1'b0);
        check("one_left", 16'(cards_left), 16'd1);
        draw_req = 1'b1;
        @(negedge clk);
        check("pick_busy", 16'(busy), 16'd1);
        rst = 1'b1; draw_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_pick_reset");
        rst = 1'b0;
        model_reset();
        do_draw(1'b0);
        check("post_reset_rank", 16'(card_rank), 16'd8);
        check("post_reset_suit", 16'(card_suit), 16'd2);

        // Alternate seed instance: first card is the king of suit 0.
        @(negedge clk);
        rst_c = 1'b0; draw_c = 1'b1;
        @(negedge clk);
        draw_c = 1'b0;
        check("seedc_busy",   16'(c_busy),       16'd1);
        check("seedc_valid0", 16'(c_card_valid), 16'd0);
        @(negedge clk);
        check("seedc_valid1", 16'(c_card_valid), 16'd0);
        @(negedge clk);
        check("seedc_valid",  16'(c_card_valid), 16'd1);
        check("seedc_rank",   16'(c_card_rank),  16'd13);
        check("seedc_suit",   16'(c_card_suit),  16'd0);
        check("seedc_value",  16'(c_card_value), 16'd10);
        check("seedc_left",   16'(c_cards_left), 16'd51);
        check("seedc_empty",  16'(c_deck_empty), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
